// File: rtl/matrix_index_gen_if.sv
// Index stream bundle between matrix_index_gen (master) and the accumulate/write stage (slave).
// ROWS/COLS must match the generator instance so the index widths agree.
interface matrix_index_gen_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int ADDR_W = $clog2(ROWS * COLS);

  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr;
  logic              last;

  modport master (
    output out_valid, row, col, addr, last,
    input  out_ready
  );

  modport slave (
    input  out_valid, row, col, addr, last,
    output out_ready
  );
endinterface

// File: rtl/matrix_index_gen.sv
// Row-major (row, col, addr) index streamer over a ROWS x COLS matrix with valid/ready output.
// Define MATRIX_INDEX_TRI_EN for an upper-triangular sweep (col >= row), which requires COLS >= ROWS.
module matrix_index_gen #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  matrix_index_gen_if.master  idx
);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int ADDR_W = $clog2(ROWS * COLS);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic col_at_end;
  logic last_idx;
  logic xfer;

  assign col_at_end = (col_q == COL_MAX);
  assign last_idx   = (row_q == ROW_MAX) && col_at_end;
  assign xfer       = (state_q == ST_RUN) && idx.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
    end
  end

  // Counters only move on an accepted transfer, so a stall and the post-sweep idle both hold them.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          row_d   = '0;
          col_d   = '0;
          addr_d  = '0;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (last_idx) begin
            state_d = ST_DONE;
          end else if (col_at_end) begin
            row_d = row_q + ROW_W'(1);
`ifdef MATRIX_INDEX_TRI_EN
            // Next row starts on the diagonal: from row*COLS+COLS-1 to (row+1)*COLS+(row+1).
            col_d  = COL_W'(row_q) + COL_W'(1);
            addr_d = addr_q + ADDR_W'(row_q) + ADDR_W'(2);
`else
            col_d  = '0;
            addr_d = addr_q + ADDR_W'(1);
`endif
          end else begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign idx.out_valid = (state_q == ST_RUN);
  assign idx.row       = row_q;
  assign idx.col       = col_q;
  assign idx.addr      = addr_q;
  assign idx.last      = last_idx;

  assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done = (state_q == ST_DONE);
endmodule

// File: tb/tb_matrix_index_gen.sv
// Scoreboard bench for matrix_index_gen (ROWS=3, COLS=4); expected sweeps are queued on start.
// Follows MATRIX_INDEX_TRI_EN so the same bench covers the triangular build.
module tb_matrix_index_gen;
  localparam int ROWS = 3;
  localparam int COLS = 4;

  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_e;

  typedef struct {
    int row;
    int col;
    int addr;
    bit last;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic abort;
  logic busy;
  logic done;

  int vectors     = 0;
  int miscompares = 0;

  entry_t  exp_q[$];
  mstate_e model_state = M_IDLE;

  matrix_index_gen_if #(.ROWS(ROWS), .COLS(COLS)) idx_if ();

  matrix_index_gen #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .idx   (idx_if)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Expected sweep built from row*COLS+col directly, independent of the incremental RTL address.
  task automatic queueSweep();
    int c0;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
`ifdef MATRIX_INDEX_TRI_EN
      c0 = r;
`else
      c0 = 0;
`endif
      for (int c = c0; c < COLS; c++) begin
        entry_t e;
        e.row  = r;
        e.col  = c;
        e.addr = r * COLS + c;
        e.last = (r == ROWS - 1) && (c == COLS - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic int sweepLen();
    int n = 0;
    for (int r = 0; r < ROWS; r++) begin
`ifdef MATRIX_INDEX_TRI_EN
      n += COLS - r;
`else
      n += COLS;
`endif
    end
    return n;
  endfunction

  task automatic checkOutput();
    cmp("out_valid", int'(idx_if.out_valid), int'(model_state == M_RUN));
    cmp("busy", int'(busy), int'(model_state != M_IDLE));
    cmp("done", int'(done), int'(model_state == M_DONE));
    if (model_state == M_RUN) begin
      if (exp_q.size() == 0) begin
        cmp("queue_underrun", 1, 0);
      end else begin
        cmp("row", int'(idx_if.row), exp_q[0].row);
        cmp("col", int'(idx_if.col), exp_q[0].col);
        cmp("addr", int'(idx_if.addr), exp_q[0].addr);
        cmp("last", int'(idx_if.last), int'(exp_q[0].last));
      end
    end
  endtask

  // Called at a falling edge: drive inputs, check the settled outputs, advance the model, wait one cycle.
  task automatic applyStimulus(input logic s, input logic a, input logic r);
    entry_t e;
    start            = s;
    abort            = a;
    idx_if.out_ready = r;
    checkOutput();
    case (model_state)
      M_IDLE: begin
        if (s) begin
          queueSweep();
          model_state = M_RUN;
        end
      end
      M_RUN: begin
        if (a) begin
          exp_q.delete();
          model_state = M_IDLE;
        end else if (r && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.last) model_state = M_DONE;
        end
      end
      default: model_state = M_IDLE;
    endcase
    @(negedge clk);
  endtask

  task automatic checkIdleIndices(input string tag);
    cmp({tag, "_valid"}, int'(idx_if.out_valid), 0);
    cmp({tag, "_busy"}, int'(busy), 0);
    cmp({tag, "_done"}, int'(done), 0);
    cmp({tag, "_row"}, int'(idx_if.row), 0);
    cmp({tag, "_col"}, int'(idx_if.col), 0);
    cmp({tag, "_addr"}, int'(idx_if.addr), 0);
    cmp({tag, "_last"}, int'(idx_if.last), 0);
  endtask

  initial begin
    int len;
    len              = sweepLen();
    rst              = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    idx_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkIdleIndices("reset");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] full-rate sweep");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < len + 2; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    cmp("sweep1_drained", exp_q.size(), 0);

    $display("[TB] ready toggling every cycle");
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * len + 3; i++) applyStimulus(1'b0, 1'b0, logic'(i % 2));
    cmp("sweep2_drained", exp_q.size(), 0);

    $display("[TB] abort after five transfers");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < len + 2; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    cmp("sweep4_drained", exp_q.size(), 0);

    $display("[TB] start held through RUN and DONE");
    for (int i = 0; i < len + 2; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    cmp("sweep5_drained", exp_q.size(), 0);

    $display("[TB] async reset mid-sweep");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1 checkIdleIndices("midrun_reset");
    exp_q.delete();
    model_state = M_IDLE;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < len + 2; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    cmp("sweep6_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
